skip_accum: RTL and testbench



---
 rtl/skip_accum_pkg.sv | 23 ++
 rtl/skip_block.sv | 32 +++
 rtl/skip_accum.sv | 140 ++++++++++++++
 tb/tb_skip_accum.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/skip_accum_pkg.sv
// Shared types and sizing helpers for the block-serial carry-skip accumulator.
package skip_accum_pkg;

   // Default number of operand bits handled per cycle (one skip block).
   localparam int unsigned BLK_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Number of skip blocks needed to cover the operand.
   function automatic int unsigned calc_nblk(input int unsigned width, input int unsigned blk);
      return width / blk;
   endfunction

   // Width of the block counter; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned nblk);
      return (nblk > 1) ? $clog2(nblk) : 1;
   endfunction

endpackage

// File: rtl/skip_block.sv
// One BLK-bit ripple block with its carry-skip term. Purely combinational;
// the enclosing accumulator owns all state.
module skip_block
   import skip_accum_pkg::*;
#(
   parameter int unsigned BLK = BLK_DEFAULT
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           cin,
   output logic [BLK-1:0] s,
   output logic           cout_next
);

   // Ripple the block, then merge the ripple carry with the skip term.
   always_comb begin
      logic [BLK:0] c;
      logic         g;
      logic         p;
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < BLK; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
      end
      g         = c[BLK];
      p         = &(a | b);
      cout_next = g | (p & cin);
   end

endmodule

// File: rtl/skip_accum.sv
// Block-serial carry-skip accumulator: adds each accepted operand into the
// accumulator one BLK-bit block per cycle, carry held in a register.
// Optional feature: define ACC_SAT_EN to saturate the accumulator to all
// ones when the final block carries out.
module skip_accum
   import skip_accum_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLK   = BLK_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int unsigned   NBLK     = calc_nblk(WIDTH, BLK);
   localparam int unsigned   CW       = cnt_width(NBLK);
   localparam logic [CW-1:0] LAST_BLK = CW'(NBLK - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc_upd;
   logic             carry;
   logic [CW-1:0]    blk;
   logic [BLK-1:0]   a_sel;
   logic [BLK-1:0]   b_sel;
   logic [BLK-1:0]   s_blk;
   logic             cout_blk;
   logic             accept;
   logic             last_run;

   assign last_run = (state == RUN) && (blk == LAST_BLK);

   // Pick the current block of accumulator and operand.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned k = 0; k < NBLK; k++) begin
         if (blk == CW'(k)) begin
            a_sel = acc[k*BLK +: BLK];
            b_sel = opnd[k*BLK +: BLK];
         end
      end
   end

   skip_block #(.BLK(BLK)) u_skip_block (
      .a         (a_sel),
      .b         (b_sel),
      .cin       (carry),
      .s         (s_blk),
      .cout_next (cout_blk)
   );

   // Merge the new block sum back into the accumulator image.
   always_comb begin
      acc_upd = acc;
      for (int unsigned k = 0; k < NBLK; k++) begin
         if (blk == CW'(k)) begin
            acc_upd[k*BLK +: BLK] = s_blk;
         end
      end
`ifdef ACC_SAT_EN
      if (last_run && cout_blk) begin
         acc_upd = '1;
      end
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode; ready/valid depend on state only.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_run) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers: operand capture, per-block accumulate, carry chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= '0;
         opnd  <= '0;
         carry <= 1'b0;
         blk   <= '0;
      end else if (accept) begin
         opnd  <= in_data;
         carry <= 1'b0;
         blk   <= '0;
         if (in_clear) begin
            acc <= '0;
         end
      end else if (state == RUN) begin
         acc   <= acc_upd;
         carry <= cout_blk;
         blk   <= blk + CW'(1);
      end
   end

   assign out_sum  = acc;
   assign out_cout = carry;

endmodule

// File: tb/tb_skip_accum.sv
// Self-checking bench for skip_accum (WIDTH=16, BLK=4): directed table,
// back-pressure, mid-operation reset and randomized operands vs a model.
module tb_skip_accum;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned BLK   = 4;
   localparam int unsigned NBLK  = WIDTH / BLK;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_clear;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   int vectors    = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] model_acc;

   skip_accum #(.WIDTH(WIDTH), .BLK(BLK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_clear  (in_clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer add with optional saturation.
   task automatic model_add(input logic [WIDTH-1:0] d, input logic clr,
                            output logic [WIDTH-1:0] e_sum, output logic e_cout);
      int unsigned base;
      int unsigned total;
      base   = clr ? 0 : int'(model_acc);
      total  = base + int'(d);
      e_cout = (total >= (1 << WIDTH));
`ifdef ACC_SAT_EN
      e_sum  = e_cout ? '1 : WIDTH'(total);
`else
      e_sum  = WIDTH'(total);
`endif
      model_acc = e_sum;
   endtask

   // One full transaction: accept, wait for result, optional back-pressure,
   // then release. Returns the observed result.
   task automatic do_op(input logic [WIDTH-1:0] d, input logic clr, input int hold,
                        output logic [WIDTH-1:0] got_sum, output logic got_cout);
      int lat;
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_clear = clr;
      tick();
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      in_clear = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'(NBLK));
      got_sum  = out_sum;
      got_cout = out_cout;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_data  = WIDTH'($urandom);
         in_clear = 1'($urandom);
         tick();
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_sum_stable", 32'(out_sum), 32'(got_sum));
         check("bp_cout_stable", 32'(out_cout), 32'(got_cout));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_out_valid", 32'(out_valid), 32'd0);
   endtask

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             clr;
      int               hold;
      logic [WIDTH-1:0] sum;
      logic             cout;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [WIDTH-1:0] gs;
      logic             gc;
      logic [WIDTH-1:0] es;
      logic             ec;

      tbl[0] = '{16'h1234, 1'b1, 0, 16'h1234, 1'b0};
      tbl[1] = '{16'h0FFF, 1'b0, 0, 16'h2233, 1'b0};
      tbl[2] = '{16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b0};
      tbl[5] = '{16'h8000, 1'b1, 1, 16'h8000, 1'b0};
`ifdef ACC_SAT_EN
      tbl[3] = '{16'h0001, 1'b0, 3, 16'hFFFF, 1'b1};
      tbl[4] = '{16'h0002, 1'b0, 0, 16'hFFFF, 1'b1};
      tbl[6] = '{16'h8000, 1'b0, 0, 16'hFFFF, 1'b1};
      tbl[7] = '{16'h00F0, 1'b0, 2, 16'hFFFF, 1'b1};
`else
      tbl[3] = '{16'h0001, 1'b0, 3, 16'h0000, 1'b1};
      tbl[4] = '{16'h0002, 1'b0, 0, 16'h0002, 1'b0};
      tbl[6] = '{16'h8000, 1'b0, 0, 16'h0000, 1'b1};
      tbl[7] = '{16'h00F0, 1'b0, 2, 16'h00F0, 1'b0};
`endif

      // Reset with a handshake offered: reset must win.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hAAAA;
      in_clear  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_cout", 32'(out_cout), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b1;
      tick();
      check("post_rst_idle", 32'(in_ready), 32'd1);
      model_acc = '0;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         do_op(tbl[i].data, tbl[i].clr, tbl[i].hold, gs, gc);
         model_add(tbl[i].data, tbl[i].clr, es, ec);
         check($sformatf("tbl%0d_sum", i), 32'(gs), 32'(tbl[i].sum));
         check($sformatf("tbl%0d_cout", i), 32'(gc), 32'(tbl[i].cout));
      end

      // Mid-operation reset on the second RUN cycle.
      in_valid = 1'b1;
      in_data  = 16'h7777;
      in_clear = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_sum", 32'(out_sum), 32'd0);
      model_acc = '0;
      do_op(16'h0005, 1'b1, 0, gs, gc);
      model_add(16'h0005, 1'b1, es, ec);
      check("midrst_next_sum", 32'(gs), 32'h0005);
      check("midrst_next_cout", 32'(gc), 32'd0);

      // Randomized operands against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [WIDTH-1:0] d;
         logic             c;
         d = WIDTH'($urandom);
         if (i % 5 == 0) d = 16'hFFFF - WIDTH'($urandom_range(0, 3));
         c = ($urandom_range(0, 3) == 0);
         model_add(d, c, es, ec);
         do_op(d, c, int'($urandom_range(0, 2)), gs, gc);
         check("rand_sum", 32'(gs), 32'(es));
         check("rand_cout", 32'(gc), 32'(ec));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
